// File: rtl/p3_sequencer.sv
// -----------------------------------------------------------------------------
// p3_sequencer
//
// Buffers forward/backward sample pairs in a small FIFO and walks each sample
// through one forward pass and one backward pass of an attached p3 unit. An
// optional weight update follows the backward pass. The result is presented
// on a valid/ready stream.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   s_valid/s_ready         sample stream handshake
//   s_fwd[2:0], s_bwd[2:0]  lane bits for the forward and backward passes
//   learn_en                store bcontrol as the new weight after this BWD
//   fcontrol, fin0..fin2    forward inputs to the p3 unit (fcontrol = weight)
//   fout0, bcontrol         p3 unit forward result and backward control result
//   bin0..bin2              backward inputs to the p3 unit (zero outside BWD)
//   m_valid/m_ready         result stream handshake
//   m_fout, m_bout          captured forward / backward results
//   weight                  current stored control bit
// -----------------------------------------------------------------------------
module p3_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [2:0] s_fwd,
    input  logic [2:0] s_bwd,
    input  logic       learn_en,
    output logic       fcontrol,
    output logic       fin0,
    output logic       fin1,
    output logic       fin2,
    input  logic       fout0,
    input  logic       bcontrol,
    output logic       bin0,
    output logic       bin1,
    output logic       bin2,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_fout,
    output logic       m_bout,
    output logic       weight
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        BWD,
        UPDATE,
        OUT
    } state_t;

    state_t         state_q, state_d;

    // FIFO storage and bookkeeping
    logic [5:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [5:0]     head;
    logic           full, push, pop;

    // Sample and result registers
    logic [2:0]     fin_q;
    logic [2:0]     hold_q;
    logic           m_fout_q, m_bout_q, weight_q;
    logic [2:0]     bin_d;

    assign full    = (count == CW'(DEPTH));
    // Readiness depends on the registered count only, so it never combinationally
    // follows s_valid; it is forced low while reset is held.
    assign s_ready = !rst_in && !full;
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == IDLE) && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage array has no reset; an entry is only read after it has been
    // written, because count gates every pop.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {s_bwd, s_fwd};
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the increment wrap modulo DEPTH without an explicit compare.
    // NOTE: all sequential state uses non-blocking assignment so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count; // simultaneous push/pop keeps occupancy
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        m_valid = 1'b0;
        bin_d   = 3'b000;
        case (state_q)
            IDLE:   if (count != '0) state_d = FWD;
            FWD:    state_d = BWD;
            BWD: begin
                bin_d   = hold_q;
                state_d = learn_en ? UPDATE : OUT;
            end
            UPDATE: state_d = OUT;
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fin_q    <= '0;
            hold_q   <= '0;
            m_fout_q <= 1'b0;
            m_bout_q <= 1'b0;
            weight_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        fin_q  <= head[2:0];
                        hold_q <= head[5:3];
                    end
                end
                FWD:    m_fout_q <= fout0;
                BWD:    m_bout_q <= bcontrol;
                UPDATE: weight_q <= m_bout_q;
                default: ;
            endcase
        end
    end

    assign fin0     = fin_q[0];
    assign fin1     = fin_q[1];
    assign fin2     = fin_q[2];
    assign bin0     = bin_d[0];
    assign bin1     = bin_d[1];
    assign bin2     = bin_d[2];
    assign m_fout   = m_fout_q;
    assign m_bout   = m_bout_q;
    assign weight   = weight_q;
    assign fcontrol = weight_q;

endmodule

// File: tb/tb_p3_sequencer.sv
// -----------------------------------------------------------------------------
// tb_p3_sequencer
//
// Self-checking bench for p3_sequencer. A behavioural p3 unit is attached to
// the forward/backward ports. Each accepted sample is run through a reference
// model (in-order processing, weight carried between samples) and the expected
// result is queued; a monitor compares every delivered result against the head
// of that queue.
// -----------------------------------------------------------------------------
module tb_p3_sequencer;

    localparam int DEPTH = 4;

    logic       clk_in;
    logic       rst_in;
    logic       s_valid;
    logic       s_ready;
    logic [2:0] s_fwd;
    logic [2:0] s_bwd;
    logic       learn_en;
    logic       fcontrol, fin0, fin1, fin2;
    logic       fout0, bcontrol;
    logic       bin0, bin1, bin2;
    logic       m_valid;
    logic       m_ready;
    logic       m_fout, m_bout, weight;

    p3_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_fwd    (s_fwd),
        .s_bwd    (s_bwd),
        .learn_en (learn_en),
        .fcontrol (fcontrol),
        .fin0     (fin0),
        .fin1     (fin1),
        .fin2     (fin2),
        .fout0    (fout0),
        .bcontrol (bcontrol),
        .bin0     (bin0),
        .bin1     (bin1),
        .bin2     (bin2),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_fout   (m_fout),
        .m_bout   (m_bout),
        .weight   (weight)
    );

    // Behavioural p3 unit: control=1 selects AND of lanes, control=0 selects OR;
    // the backward control result is the OR of the backward lanes.
    assign fout0    = fcontrol ? (fin0 & fin1 & fin2) : (fin0 | fin1 | fin2);
    assign bcontrol = bin0 | bin1 | bin2;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic fout;
        logic bout;
        logic w;
    } exp_t;

    exp_t exp_q[$];
    bit   model_w;
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples are processed strictly in arrival order; the
    // forward result uses the weight left by the previous sample.
    task automatic model_push(input logic [2:0] f, input logic [2:0] b, input logic learn);
        exp_t e;
        e.fout = model_w ? (&f) : (|f);
        e.bout = |b;
        if (learn) model_w = e.bout;
        e.w = model_w;
        exp_q.push_back(e);
    endtask

    // Monitor: a result transfers at the next rising edge when valid and ready
    // are both high at the falling edge.
    always @(negedge clk_in) begin
        if (!rst_in && m_valid && m_ready) begin
            check("result_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_fout", 32'(m_fout), 32'(e.fout));
                check("m_bout", 32'(m_bout), 32'(e.bout));
                check("weight", 32'(weight), 32'(e.w));
                check("fcontrol", 32'(fcontrol), 32'(e.w));
            end
        end
    end

    task automatic sync();
        @(posedge clk_in);
        #1;
    endtask

    // Offers one sample and waits (bounded) until it is accepted; returns just
    // after the accepting edge.
    task automatic push_sample(input logic [2:0] f, input logic [2:0] b);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_fwd   = f;
        s_bwd   = b;
        @(negedge clk_in);
        while (!s_ready && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check("push_accept_timeout", 32'(guard < 50), 32'd1);
        model_push(f, b, learn_en);
        @(posedge clk_in);
        #1;
        s_valid = 1'b0;
    endtask

    // Waits until all expected results have been delivered.
    task automatic drain(input bit random_ready);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 1000) begin
            m_ready = random_ready ? 1'($urandom) : 1'b1;
            sync();
            g++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        repeat (2) sync();
    endtask

    // Single sample from an empty FIFO: checks the pass timing and the first
    // edge at which m_valid is seen high, counted from the accepting edge N.
    task automatic single(input logic [2:0] f, input logic [2:0] b, input logic learn,
                          input int exp_first);
        int first;
        first    = -1;
        learn_en = learn;
        m_ready  = 1'b1;
        push_sample(f, b);
        // Iteration e observes the cycle between edges N+e and N+e+1.
        for (int e = 0; e < 8; e++) begin
            @(negedge clk_in);
            if (e == 1) begin
                check("fin_during_fwd", 32'({fin2, fin1, fin0}), 32'(f));
                check("bin_zero_in_fwd", 32'({bin2, bin1, bin0}), 32'd0);
            end
            if (e == 2) check("bin_during_bwd", 32'({bin2, bin1, bin0}), 32'(b));
            if (e == exp_first - 1) begin
                check("weight_at_out", 32'(weight), 32'(model_w));
                check("fcontrol_at_out", 32'(fcontrol), 32'(model_w));
            end
            if (m_valid && first < 0) first = e + 1;
        end
        check("m_valid_latency", 32'(first), 32'(exp_first));
        sync();
    endtask

    // Randomised stream of n samples with random gaps and random m_ready.
    task automatic stream(input int n, input logic learn);
        int cnt;
        int guard;
        cnt      = 0;
        guard    = 0;
        learn_en = learn;
        s_valid  = 1'($urandom);
        s_fwd    = 3'($urandom);
        s_bwd    = 3'($urandom);
        while (cnt < n && guard < 2000) begin
            @(negedge clk_in);
            if (s_valid && s_ready) begin
                model_push(s_fwd, s_bwd, learn);
                cnt++;
            end
            sync();
            guard++;
            m_ready = 1'($urandom);
            s_valid = (cnt < n - 1) ? ($urandom_range(3) != 0) : ($urandom_range(3) != 0) && (cnt < n);
            s_fwd   = 3'($urandom);
            s_bwd   = 3'($urandom);
        end
        s_valid = 1'b0;
        check("stream_count", 32'(cnt), 32'(n));
        drain(1'b1);
    endtask

    initial begin
        int acc;
        bit saw_valid;

        checks   = 0;
        errors   = 0;
        model_w  = 1'b0;
        rst_in   = 1'b1;
        s_valid  = 1'b0;
        s_fwd    = '0;
        s_bwd    = '0;
        learn_en = 1'b0;
        m_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_weight", 32'(weight), 32'd0);
        check("rst_fin", 32'({fcontrol, fin2, fin1, fin0}), 32'd0);
        check("rst_bin", 32'({bin2, bin1, bin0}), 32'd0);
        check("rst_results", 32'({m_fout, m_bout}), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("s_ready_after_release", 32'(s_ready), 32'd1);
        sync();

        // Single sample without learning, then with learning, then a sample
        // that must see the learned weight.
        single(3'b011, 3'b101, 1'b0, 4);
        check("weight_unchanged", 32'(weight), 32'd0);
        single(3'b001, 3'b111, 1'b1, 5);
        check("weight_learned", 32'(weight), 32'd1);
        single(3'b011, 3'b000, 1'b0, 4);
        check("weight_persists", 32'(fcontrol), 32'd1);

        // Backpressure: DEPTH+1 samples accepted, then s_ready falls
        learn_en = 1'b0;
        m_ready  = 1'b0;
        acc      = 0;
        s_valid  = 1'b1;
        for (int c = 0; c < DEPTH + 4; c++) begin
            s_fwd = 3'($urandom);
            s_bwd = 3'($urandom);
            @(negedge clk_in);
            if (s_ready) begin
                model_push(s_fwd, s_bwd, learn_en);
                acc++;
            end
            sync();
        end
        s_valid = 1'b0;
        check("accepted_until_full", 32'(acc), 32'(DEPTH + 1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            check("full_s_ready_low", 32'(s_ready), 32'd0);
            check("held_m_valid", 32'(m_valid), 32'd1);
            check("held_m_fout", 32'(m_fout), 32'(exp_q[0].fout));
            check("held_m_bout", 32'(m_bout), 32'(exp_q[0].bout));
        end
        sync();
        drain(1'b0);

        // Wrap-around with random traffic, without and with learning
        stream(3 * DEPTH, 1'b0);
        stream(3 * DEPTH, 1'b1);

        // Push landing in the same cycle as an IDLE pop
        learn_en = 1'b0;
        m_ready  = 1'b1;
        push_sample(3'b100, 3'b010);
        push_sample(3'b110, 3'b000);
        drain(1'b0);

        // Reset during BWD of the first sample with two entries queued
        push_sample(3'b101, 3'b110);
        push_sample(3'b010, 3'b011);
        push_sample(3'b111, 3'b001);
        check("pre_reset_in_bwd", 32'({bin2, bin1, bin0}), 32'b110);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_m_valid", 32'(m_valid), 32'd0);
        check("async_rst_bin", 32'({bin2, bin1, bin0}), 32'd0);
        check("async_rst_fin", 32'({fcontrol, fin2, fin1, fin0}), 32'd0);
        check("async_rst_weight", 32'(weight), 32'd0);
        check("async_rst_results", 32'({m_fout, m_bout}), 32'd0);
        check("async_rst_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        model_w = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("s_ready_after_mid_reset", 32'(s_ready), 32'd1);
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            saw_valid |= m_valid;
        end
        check("no_result_after_reset", 32'(saw_valid), 32'd0);
        sync();

        // Recovery after reset
        stream(DEPTH, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/p3_sequencer.md
P3_SEQUENCER -- requirements
Module: p3_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, sample FIFO depth; power of two, >=2.
REQ-002 Ports: clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 Ports: rst_in  input  1  asynchronous, active-high reset.
REQ-004 Ports: s_valid input 1, s_ready output 1, s_fwd input 3, s_bwd input 3: sample stream; bit i of s_fwd/s_bwd maps to lane i.
REQ-005 Ports: learn_en  input  1  enables weight update on the current sample's backward pass.
REQ-006 Ports: fcontrol, fin0, fin1, fin2  output  1 each  drive the downstream p3 unit's forward inputs.
REQ-007 Ports: fout0, bcontrol  input  1 each  p3 unit forward result and backward control result.
REQ-008 Ports: bin0, bin1, bin2  output  1 each  drive the p3 unit's backward inputs.
REQ-009 Ports: m_valid output 1, m_ready input 1, m_fout output 1, m_bout output 1: result stream.
REQ-010 Ports: weight  output  1  current stored control bit; fcontrol equals weight at all times.

Function
REQ-011 FIFO holds DEPTH 6-bit entries {s_bwd, s_fwd}; push when s_valid && s_ready; s_ready = !full, derived from registered count only.
REQ-012 Count width is clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH; push into a full FIFO is impossible by construction.
REQ-013 Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-014 FSM states: IDLE, FWD, BWD, UPDATE, OUT.
REQ-015 IDLE: if count != 0, pop the head entry, register fwd bits into fin0..2 and bwd bits into an internal hold register, go to FWD; otherwise stay.
REQ-016 FWD: fin0..2 held, bin0..2 = 0; capture fout0 into m_fout at the end of the cycle; go to BWD.
REQ-017 BWD: bin0..2 = held bwd bits; capture bcontrol into m_bout; go to UPDATE if learn_en is high in this cycle, else to OUT.
REQ-018 UPDATE: weight <= m_bout; go to OUT. Weight changes only in this state.
REQ-019 OUT: m_valid = 1, m_fout/m_bout stable; on m_valid && m_ready go to IDLE; hold indefinitely otherwise.
REQ-020 m_valid is 1 only in OUT; bin0..2 are 0 outside BWD; fin0..2 hold the last popped value outside FWD/BWD.
REQ-021 Latency, empty FIFO, m_ready high, push accepted at edge N: FWD in N+1..N+2, m_valid first high cycle N+4 (learn_en=0) or N+5 (learn_en=1).
REQ-022 Throughput: one sample per 4 cycles (5 with learning); FIFO continues accepting during processing until full.

Reset
REQ-023 rst_in high asynchronously forces: state IDLE, FIFO empty (count 0, pointers 0), weight 0, fcontrol 0, fin0..2 0, bin0..2 0, m_fout 0, m_bout 0, m_valid 0, s_ready 0 while rst_in is high, 1 from the first cycle after release.
REQ-024 Reset mid-operation discards the in-flight sample and all queued entries; no partial result is presented after release.

Verification
REQ-025 Single sample: s_fwd=3'b011, s_bwd=3'b101, learn_en=0, model p3 unit attached -> fin=011 during FWD, bin=101 during BWD, m_fout=1, m_bout=1, m_valid at N+4, weight stays 0.
REQ-026 Learning: s_fwd=3'b001, s_bwd=3'b111, learn_en=1 -> m_bout=1, weight and fcontrol become 1 at N+5 and persist for the following sample.
REQ-027 Backpressure/full: m_ready=0, push DEPTH+1 samples back-to-back -> s_ready falls after DEPTH+1 total accepted (one popped, DEPTH queued); m_valid held, m_fout/m_bout stable; release m_ready -> all results delivered in order, none lost or duplicated.
REQ-028 Wrap-around: stream 3*DEPTH random samples with random m_ready -> results match reference model in order; pointers wrap without corruption.
REQ-029 Simultaneous push/pop: with count=1 in IDLE, push in the same cycle -> count stays 1, both entries processed in order.
REQ-030 Reset mid-BWD with 2 queued entries: assert rst_in asynchronously -> all outputs immediately at reset values; after release, m_valid stays 0 until a new push.
